// File: rtl/trap_sequencer.sv
// trap_sequencer: arbitrates exceptions, prioritised interrupts and CSR access; captures mepc/mcause/mtval and sequences flush/redirect.
// Optional VECTORED_MODE_EN: with mtvec_i[0]=1, interrupt redirects go to base + 4*index.
module trap_sequencer #(
    parameter int XLEN         = 64,
    parameter int NUM_IRQ      = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int CAUSE_W      = 6
) (
    input  logic               clock_i,
    input  logic               reset_ni,
    input  logic               csr_access_request_i,
    output logic               csr_grant_o,
    input  logic               exception_valid_i,
    input  logic [CAUSE_W-1:0] exception_cause_i,
    input  logic [XLEN-1:0]    exception_pc_i,
    input  logic [XLEN-1:0]    exception_tval_i,
    input  logic [NUM_IRQ-1:0] irq_pending_i,
    input  logic               irq_global_en_i,
    input  logic               retire_i,
    input  logic [XLEN-1:0]    retire_pc_i,
    input  logic               mret_i,
    input  logic [XLEN-1:0]    mtvec_i,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o,
    output logic [XLEN-1:0]    mepc_o,
    output logic [XLEN-1:0]    mcause_o,
    output logic [XLEN-1:0]    mtval_o,
    output logic               busy_o
);
    typedef enum logic [2:0] {
        RESET, IDLE, CSR_READ, CSR_MODIFY, WAIT_FOR_RETIRE, FLUSH, REDIRECT, WAIT_FOR_RETURN
    } state_t;

    state_t          state;
    logic [3:0]      flush_cnt;
    logic [3:0]      irq_idx;
    logic [XLEN-1:0] base;
    logic [XLEN-1:0] vec_off;
    logic            take_exc;
    logic            take_irq;

    function automatic logic [3:0] lowest(input logic [NUM_IRQ-1:0] p);
        lowest = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) if (p[i]) lowest = 4'(i);
    endfunction

    assign irq_idx  = lowest(irq_pending_i);
    assign base     = {mtvec_i[XLEN-1:2], 2'b00};
    assign take_exc = exception_valid_i &&
                      (state == IDLE || state == WAIT_FOR_RETIRE || state == WAIT_FOR_RETURN);
    assign take_irq = state == WAIT_FOR_RETIRE && retire_i && |irq_pending_i;

`ifdef VECTORED_MODE_EN
    assign vec_off = (mtvec_i[0] && mcause_o[XLEN-1]) ? {mcause_o[XLEN-3:0], 2'b00} : '0;
`else
    logic unused_mtvec_bits;
    assign unused_mtvec_bits = ^mtvec_i[1:0];
    assign vec_off = '0;
`endif

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state            <= RESET;
            flush_cnt        <= '0;
            csr_grant_o      <= 1'b0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            mepc_o           <= '0;
            mcause_o         <= '0;
            mtval_o          <= '0;
            busy_o           <= 1'b0;
        end else begin
            csr_grant_o      <= 1'b0;
            flush_o          <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            if (take_exc || take_irq) begin
                mepc_o    <= take_exc ? exception_pc_i : retire_pc_i;
                mcause_o  <= take_exc ? XLEN'(exception_cause_i) : {1'b1, (XLEN-1)'(irq_idx)};
                mtval_o   <= take_exc ? exception_tval_i : '0;
                flush_cnt <= 4'(FLUSH_CYCLES);
                flush_o   <= 1'b1;
                busy_o    <= 1'b1;
                state     <= FLUSH;
            end else begin
                case (state)
                    RESET: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    IDLE: begin
                        if (irq_global_en_i && |irq_pending_i) begin
                            state  <= WAIT_FOR_RETIRE;
                            busy_o <= 1'b1;
                        end else if (csr_access_request_i) begin
                            state  <= CSR_READ;
                            busy_o <= 1'b1;
                        end
                    end
                    CSR_READ: begin
                        state       <= CSR_MODIFY;
                        csr_grant_o <= 1'b1;
                    end
                    CSR_MODIFY: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    // Retire with no line still pending abandons the interrupt.
                    WAIT_FOR_RETIRE: begin
                        if (retire_i) begin
                            state  <= IDLE;
                            busy_o <= 1'b0;
                        end
                    end
                    FLUSH: begin
                        if (flush_cnt <= 4'd1) begin
                            state            <= REDIRECT;
                            redirect_valid_o <= 1'b1;
                            redirect_pc_o    <= base + vec_off;
                        end else begin
                            flush_cnt <= flush_cnt - 4'd1;
                            flush_o   <= 1'b1;
                        end
                    end
                    REDIRECT: state <= WAIT_FOR_RETURN;
                    WAIT_FOR_RETURN: begin
                        if (mret_i) begin
                            state            <= IDLE;
                            busy_o           <= 1'b0;
                            redirect_valid_o <= 1'b1;
                            redirect_pc_o    <= mepc_o;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: scenario tasks with a redirect scoreboard for trap_sequencer.
module tb_trap_sequencer;
    localparam int XLEN = 64;
    localparam int NUM_IRQ = 4;
    localparam int CAUSE_W = 6;

    logic               clock_i = 1'b0;
    logic               reset_ni = 1'b0;
    logic               csr_access_request_i = 1'b0;
    logic               csr_grant_o;
    logic               exception_valid_i = 1'b0;
    logic [CAUSE_W-1:0] exception_cause_i = '0;
    logic [XLEN-1:0]    exception_pc_i = '0;
    logic [XLEN-1:0]    exception_tval_i = '0;
    logic [NUM_IRQ-1:0] irq_pending_i = '0;
    logic               irq_global_en_i = 1'b0;
    logic               retire_i = 1'b0;
    logic [XLEN-1:0]    retire_pc_i = '0;
    logic               mret_i = 1'b0;
    logic [XLEN-1:0]    mtvec_i = '0;
    logic               flush_o;
    logic               redirect_valid_o;
    logic [XLEN-1:0]    redirect_pc_o;
    logic [XLEN-1:0]    mepc_o;
    logic [XLEN-1:0]    mcause_o;
    logic [XLEN-1:0]    mtval_o;
    logic               busy_o;

    int errors = 0;
    int checks = 0;
    logic [XLEN-1:0] exp_q[$];

    trap_sequencer #(.XLEN(XLEN), .NUM_IRQ(NUM_IRQ), .FLUSH_CYCLES(2), .CAUSE_W(CAUSE_W)) dut (
        .clock_i(clock_i), .reset_ni(reset_ni),
        .csr_access_request_i(csr_access_request_i), .csr_grant_o(csr_grant_o),
        .exception_valid_i(exception_valid_i), .exception_cause_i(exception_cause_i),
        .exception_pc_i(exception_pc_i), .exception_tval_i(exception_tval_i),
        .irq_pending_i(irq_pending_i), .irq_global_en_i(irq_global_en_i),
        .retire_i(retire_i), .retire_pc_i(retire_pc_i), .mret_i(mret_i), .mtvec_i(mtvec_i),
        .flush_o(flush_o), .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o),
        .mepc_o(mepc_o), .mcause_o(mcause_o), .mtval_o(mtval_o), .busy_o(busy_o)
    );

    always #5 clock_i = ~clock_i;

    // Every redirect strobe must match the oldest expected target; pc must be 0 otherwise.
    always @(negedge clock_i) begin
        if (redirect_valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL redirect_unexpected: got pc=%h, none expected", redirect_pc_o);
            end else begin
                logic [XLEN-1:0] e;
                e = exp_q.pop_front();
                if (redirect_pc_o !== e) begin
                    errors++;
                    $display("FAIL redirect_pc: got %h expected %h", redirect_pc_o, e);
                end
            end
        end else if (reset_ni) begin
            checks++;
            if (redirect_pc_o !== '0) begin
                errors++;
                $display("FAIL redirect_pc_idle: got %h expected 0", redirect_pc_o);
            end
        end
    end

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drain_flush(input int expect_cycles);
        int n = 0;
        while (flush_o === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== expect_cycles) begin
            errors++;
            $display("FAIL flush_length: got %0d cycles expected %0d", n, expect_cycles);
        end
        tick();
    endtask

    task automatic mret_return(input logic [XLEN-1:0] pc);
        mret_i = 1'b1;
        exp_q.push_back(pc);
        tick();
        mret_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mret_idle: busy got %b expected 0", busy_o);
        end
        tick();
    endtask

    task automatic test_reset();
        reset_ni = 1'b0;
        tick();
        reset_ni = 1'b1;
        repeat (3) tick();
        checks++;
        if ({csr_grant_o, flush_o, redirect_valid_o, busy_o} !== 4'b0 ||
            redirect_pc_o !== '0 || mepc_o !== '0 || mcause_o !== '0 || mtval_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs: grant=%b flush=%b rv=%b busy=%b mepc=%h mcause=%h mtval=%h",
                     csr_grant_o, flush_o, redirect_valid_o, busy_o, mepc_o, mcause_o, mtval_o);
        end
    endtask

    task automatic test_exception();
        mtvec_i = 64'h8000;
        exception_valid_i = 1'b1;
        exception_cause_i = 6'd2;
        exception_pc_i = 64'h1000;
        exception_tval_i = 64'hBAD;
        exp_q.push_back(64'h8000);
        tick();
        exception_valid_i = 1'b0;
        checks++;
        if (mepc_o !== 64'h1000 || mcause_o !== 64'd2 || mtval_o !== 64'hBAD) begin
            errors++;
            $display("FAIL exc_capture: mepc=%h mcause=%h mtval=%h expected 1000/2/bad", mepc_o, mcause_o, mtval_o);
        end
        drain_flush(2);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL exc_wait_return: busy got %b expected 1", busy_o);
        end
        mret_return(64'h1000);
    endtask

    task automatic test_interrupt();
        mtvec_i = 64'h8001;
        irq_global_en_i = 1'b1;
        irq_pending_i = 4'b0110;
        tick();
        checks++;
        if (busy_o !== 1'b1 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL irq_wait_retire: busy=%b flush=%b expected 1/0", busy_o, flush_o);
        end
        tick();
        tick();
        retire_i = 1'b1;
        retire_pc_i = 64'h2004;
`ifdef VECTORED_MODE_EN
        exp_q.push_back(64'h8004);
`else
        exp_q.push_back(64'h8000);
`endif
        tick();
        retire_i = 1'b0;
        irq_pending_i = '0;
        checks++;
        if (mcause_o !== 64'h8000_0000_0000_0001 || mepc_o !== 64'h2004 || mtval_o !== '0) begin
            errors++;
            $display("FAIL irq_capture: mcause=%h mepc=%h mtval=%h", mcause_o, mepc_o, mtval_o);
        end
        drain_flush(2);
        mret_return(64'h2004);
        irq_global_en_i = 1'b0;
        mtvec_i = 64'h8000;
    endtask

    task automatic test_irq_dropped();
        logic [XLEN-1:0] old_mepc;
        old_mepc = mepc_o;
        irq_global_en_i = 1'b1;
        irq_pending_i = 4'b1000;
        tick();
        irq_pending_i = '0;
        retire_i = 1'b1;
        retire_pc_i = 64'h5550;
        tick();
        retire_i = 1'b0;
        irq_global_en_i = 1'b0;
        checks++;
        if (busy_o !== 1'b0 || flush_o !== 1'b0 || mepc_o !== old_mepc) begin
            errors++;
            $display("FAIL irq_dropped: busy=%b flush=%b mepc=%h expected 0/0/%h", busy_o, flush_o, mepc_o, old_mepc);
        end
    endtask

    task automatic test_csr_priority();
        int early_grants = 0;
        csr_access_request_i = 1'b1;
        irq_pending_i = 4'b0001;
        irq_global_en_i = 1'b1;
        tick();
        retire_i = 1'b1;
        retire_pc_i = 64'h4000;
        exp_q.push_back(64'h8000);
        tick();
        retire_i = 1'b0;
        irq_pending_i = '0;
        for (int i = 0; i < 5; i++) begin
            if (csr_grant_o !== 1'b0) early_grants++;
            tick();
        end
        checks++;
        if (early_grants !== 0 || mcause_o !== 64'h8000_0000_0000_0000) begin
            errors++;
            $display("FAIL csr_blocked: early grants=%0d mcause=%h expected 0/8000000000000000", early_grants, mcause_o);
        end
        mret_i = 1'b1;
        exp_q.push_back(64'h4000);
        tick();
        mret_i = 1'b0;
        tick();
        csr_access_request_i = 1'b0;
        tick();
        checks++;
        if (csr_grant_o !== 1'b1) begin
            errors++;
            $display("FAIL csr_after_trap: grant got %b expected 1", csr_grant_o);
        end
        tick();
        irq_global_en_i = 1'b0;
        irq_pending_i = 4'b0001;
        csr_access_request_i = 1'b1;
        tick();
        csr_access_request_i = 1'b0;
        checks++;
        if (csr_grant_o !== 1'b0) begin
            errors++;
            $display("FAIL csr_read_cycle: grant got %b expected 0", csr_grant_o);
        end
        tick();
        checks++;
        if (csr_grant_o !== 1'b1) begin
            errors++;
            $display("FAIL csr_masked_grant: grant got %b expected 1", csr_grant_o);
        end
        tick();
        irq_pending_i = '0;
        checks++;
        if (csr_grant_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL csr_done: grant=%b busy=%b expected 0/0", csr_grant_o, busy_o);
        end
    endtask

    task automatic test_nested();
        exception_valid_i = 1'b1;
        exception_cause_i = 6'd3;
        exception_pc_i = 64'h500;
        exception_tval_i = 64'h11;
        exp_q.push_back(64'h8000);
        tick();
        exception_valid_i = 1'b0;
        drain_flush(2);
        mret_i = 1'b1;
        exception_valid_i = 1'b1;
        exception_cause_i = 6'd5;
        exception_pc_i = 64'h3000;
        exception_tval_i = 64'h77;
        exp_q.push_back(64'h8000);
        tick();
        mret_i = 1'b0;
        exception_valid_i = 1'b0;
        checks++;
        if (mcause_o !== 64'd5 || mepc_o !== 64'h3000 || mtval_o !== 64'h77 ||
            flush_o !== 1'b1 || redirect_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL nested_exc: mcause=%h mepc=%h mtval=%h flush=%b rv=%b", mcause_o, mepc_o, mtval_o, flush_o, redirect_valid_o);
        end
        drain_flush(2);
        mret_return(64'h3000);
    endtask

    task automatic test_reset_mid_trap();
        exception_valid_i = 1'b1;
        exception_cause_i = 6'd7;
        exception_pc_i = 64'h6000;
        tick();
        exception_valid_i = 1'b0;
        #1;
        reset_ni = 1'b0;
        #1;
        checks++;
        if (flush_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: flush=%b busy=%b expected 0/0", flush_o, busy_o);
        end
        tick();
        reset_ni = 1'b1;
        tick();
        tick();
        checks++;
        if (mepc_o !== '0 || mcause_o !== '0 || flush_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_clear: mepc=%h mcause=%h flush=%b busy=%b", mepc_o, mcause_o, flush_o, busy_o);
        end
    endtask

    initial begin
        test_reset();
        test_exception();
        test_interrupt();
        test_irq_dropped();
        test_csr_priority();
        test_nested();
        test_reset_mid_trap();
        tick();
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL redirect_missing: %0d expected redirects never seen", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
